// File: rtl/dmem_access_unit_if.sv
// Data-memory request/grant/read-valid bus between the access unit (master) and the memory (slave).
interface dmem_access_unit_if #(
    parameter int unsigned DMEM_ADDR_W = 10
);
    logic                   o_req;
    logic                   o_we;
    logic [3:0]             o_be;
    logic [DMEM_ADDR_W-1:0] o_addr;
    logic [31:0]            o_wdata;
    logic                   i_gnt;
    logic                   i_rvalid;

    modport master (
        output o_req, o_we, o_be, o_addr, o_wdata,
        input  i_gnt, i_rvalid
    );

    modport slave (
        input  o_req, o_we, o_be, o_addr, o_wdata,
        output i_gnt, i_rvalid
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Memory-stage request engine: alignment check, byte-enable/data replication, req/gnt/rvalid
// sequencing and load-side sideband for the downstream load alignment stage.
module dmem_access_unit #(
    parameter int unsigned DMEM_ADDR_W = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    input  logic                i_load,
    input  logic                i_store,
    input  logic [2:0]          i_funct3,
    input  logic [31:0]         i_addr,
    input  logic [31:0]         i_wdata,
    output logic                o_stall,
    output logic                o_misaligned,
    output logic                o_done,
    output logic                o_load,
    output logic [1:0]          o_addr_lsb,
    output logic [2:0]          o_funct3,
    dmem_access_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [3:0]             be_q, be_d;
    logic [DMEM_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   mis_q, mis_d;
    logic                   done_q, done_d;
    logic                   load_q, load_d;
    logic [1:0]             lsb_q, lsb_d;
    logic [2:0]             f3_q, f3_d;

    logic                   op;
    logic                   misaligned;
    logic [3:0]             be_new;
    logic [31:0]            wdata_new;

    // Upper byte-address bits beyond the memory depth are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_addr[31:DMEM_ADDR_W+2];

    // Request decode: op qualification, alignment, lane enables and store-data replication.
    always_comb begin
        op         = i_valid & (i_load | i_store);
        misaligned = ((i_funct3[1:0] == 2'b01) & i_addr[0])
                   | (i_funct3[1] & (i_addr[1:0] != 2'b00));
        case (i_funct3[1:0])
            2'b00: begin
                be_new    = 4'(4'b0001 << i_addr[1:0]);
                wdata_new = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                be_new    = i_addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{i_wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = i_wdata;
            end
        endcase
    end

    assign o_stall = (state_q != IDLE) | op;

    // Next-state and next-output logic; everything holds unless a transition updates it.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mis_d   = 1'b0;
        done_d  = 1'b0;
        load_d  = load_q;
        lsb_d   = lsb_q;
        f3_d    = f3_q;

        case (state_q)
            IDLE: begin
                if (op) begin
                    if (misaligned) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = ~i_load;
                        be_d    = be_new;
                        addr_d  = i_addr[DMEM_ADDR_W+1:2];
                        wdata_d = i_load ? 32'd0 : wdata_new;
                        load_d  = i_load;
                        lsb_d   = i_addr[1:0];
                        f3_d    = i_funct3;
                    end
                end
            end
            REQ: begin
                if (bus.i_gnt) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        load_d  = 1'b0;
                    end else begin
                        state_d = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (bus.i_rvalid) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    load_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                load_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            mis_q   <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            lsb_q   <= 2'd0;
            f3_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            done_q  <= done_d;
            load_q  <= load_d;
            lsb_q   <= lsb_d;
            f3_q    <= f3_d;
        end
    end

    assign bus.o_req     = req_q;
    assign bus.o_we      = we_q;
    assign bus.o_be      = be_q;
    assign bus.o_addr    = addr_q;
    assign bus.o_wdata   = wdata_q;
    assign o_misaligned  = mis_q;
    assign o_done        = done_q;
    assign o_load        = load_q;
    assign o_addr_lsb    = lsb_q;
    assign o_funct3      = f3_q;

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory-stage request engine that sits directly upstream of the load alignment stage and the data memory.
- Accepts load/store ops from EX, checks alignment, and generates the word address, byte enables and replicated store data.
- Drives a req/gnt/rvalid data-memory bus and stalls the pipeline until each access completes.
- For loads, presents the captured load flag, address LSBs and funct3 to the load alignment stage, aligned with the returning read data.

Parameters:
DMEM_ADDR_W, 10, word-address width of data memory (o_addr = i_addr[DMEM_ADDR_W+1:2])

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
i_valid  in  1  EX presents a memory op this cycle
i_load  in  1  op is a load
i_store  in  1  op is a store
i_funct3  in  3  RISC-V funct3 (size in [1:0], unsigned in [2])
i_addr  in  32  effective byte address
i_wdata  in  32  store data (rs2)
o_stall  out  1  hold upstream pipeline
o_misaligned  out  1  one-cycle pulse: misaligned access rejected
o_done  out  1  one-cycle pulse: access completed
o_req  out  1  bus request
o_we  out  1  bus write enable
o_be  out  4  bus byte enables
o_addr  out  DMEM_ADDR_W  bus word address
o_wdata  out  32  bus write data
i_gnt  in  1  bus accepted request (sampled while o_req=1)
i_rvalid  in  1  read data valid on bus this cycle
o_load  out  1  to load stage: captured load flag
o_addr_lsb  out  2  to load stage: captured i_addr[1:0]
o_funct3  out  3  to load stage: captured funct3

Behaviour:
- Reset: all outputs 0; FSM to IDLE. Reset wins over every other event, including mid-access. An i_rvalid or i_gnt arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT_R.
- Op definition: op = i_valid & (i_load | i_store). If both i_load and i_store are set, load takes priority.
- Alignment: misaligned = (size==01 & addr[0]) | (size[1] & addr[1:0]!=00).
- IDLE, op and misaligned:
  - Next cycle o_misaligned=1 for exactly one cycle.
  - No bus request is issued; state stays IDLE.
- IDLE, op and aligned: capture all request fields; next state REQ.
- Registered bus outputs (valid from cycle T+1 after accept cycle T):
  - o_req=1, o_we=store, o_addr=i_addr[DMEM_ADDR_W+1:2].
  - Size 00: o_be=0001<<addr[1:0], o_wdata={4{rs2[7:0]}}.
  - Size 01: o_be=addr[1]?1100:0011, o_wdata={2{rs2[15:0]}}.
  - Size 1x: o_be=1111, o_wdata=rs2.
  - Loads use the same o_be; o_wdata=0.
- REQ: o_req and all bus fields held stable until i_gnt=1.
  - On gnt, store: o_req=0, state IDLE, o_done=1 next cycle.
  - On gnt, load: o_req=0, state WAIT_R.
- WAIT_R: wait any number of cycles for i_rvalid.
  - i_rvalid in the same cycle as gnt is not accepted; earliest rvalid is the cycle after gnt.
  - On i_rvalid: state IDLE; o_done=1 next cycle.
- o_load/o_addr_lsb/o_funct3: loaded at accept and held through the i_rvalid cycle. o_load is cleared when returning to IDLE; the other two keep their last value.
- o_stall (combinational) = (state!=IDLE) | (IDLE & op). It is 0 on the o_done cycle and on the o_misaligned pulse cycle.
- While the FSM is not IDLE, i_valid is ignored (upstream is stalled).
- Minimum latency with zero wait states:
  - Store: accept T, gnt T+1, o_done T+2.
  - Load: accept T, gnt T+1, rvalid T+2, o_done T+3.
- i_rvalid is ignored outside WAIT_R; i_gnt is ignored outside REQ.

Test Plan:
- SB, addr=0x103, rs2=0xAABBCCDD, gnt at T+1 → T+1: o_req=1, o_we=1, o_be=1000, o_addr=0x040, o_wdata=0xDDDDDDDD; o_done at T+2; o_stall high at T and T+1 only.
- LH, addr=0x22, funct3=101, gnt delayed 3 cycles, rvalid 2 cycles after gnt → o_be=1100 held stable during wait; o_load=1, o_addr_lsb=10, o_funct3=101 held through rvalid; o_done the cycle after rvalid.
- LW, addr=0x06 → o_misaligned pulse at T+1, o_req stays 0, no o_done. SH at addr=0x05 → same response.
- Back-to-back SW 0x10 then LW 0x10, zero wait → second op accepted on the o_done cycle of the first; no lost or duplicated o_req.
- Reset asserted in WAIT_R, then i_rvalid=1 the following cycle → after reset all outputs 0, state IDLE; o_done stays 0.
- i_load=i_store=1, funct3=010, addr=0x8 → treated as LW: o_we=0, o_be=1111, o_load=1.
